exc_checker: RTL and testbench

- Memory-stage exception checker for the pipelined MIPS CPU.
- Merges the exception code carried from earlier stages with data-memory access faults: misalignment, out-of-range address, illegal timer access, and address-calculation overflow.
- Output is registered, so the final exception code travels with the instruction into the next pipeline stage.

---
 rtl/exc_pkg.sv | 20 ++
 rtl/exc_addr_fault.sv | 52 +++++
 rtl/exc_checker.sv | 66 ++++++
 tb/tb_exc_checker.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared constants for the memory-stage exception checker: exception codes,
// data-memory access widths and the default address map.
package exc_pkg;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [3:0] DM_BYTE = 4'd0;
    localparam logic [3:0] DM_HALF = 4'd1;
    localparam logic [3:0] DM_WORD = 4'd2;

    localparam logic [31:0] DEF_DM_TOP    = 32'h0000_2FFF;
    localparam logic [31:0] DEF_T0_BASE   = 32'h0000_7F00;
    localparam logic [31:0] DEF_T1_BASE   = 32'h0000_7F10;
    localparam logic [31:0] DEF_T_CNT_OFS = 32'd8;
    localparam logic [31:0] T_BLOCK_LAST  = 32'd11;

endpackage

// File: rtl/exc_addr_fault.sv
// Combinational data-memory fault detector: alignment, reserved width,
// address range and timer register access rules.
module exc_addr_fault
    import exc_pkg::*;
#(
    parameter logic [31:0] DM_TOP    = DEF_DM_TOP,
    parameter logic [31:0] T0_BASE   = DEF_T0_BASE,
    parameter logic [31:0] T1_BASE   = DEF_T1_BASE,
    parameter logic [31:0] T_CNT_OFS = DEF_T_CNT_OFS
) (
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_mode,
    input  logic        i_unaligned,
    input  logic        i_is_store,
    output logic        o_fault
);

    logic [31:0] w_addr;
    logic        w_reserved;
    logic        w_misalign;
    logic        w_in_dm;
    logic        w_in_t0;
    logic        w_in_t1;
    logic        w_in_timer;
    logic        w_cnt_hit;
    logic        w_timer_fault;

    // Unaligned-class accesses touch the whole enclosing word.
    assign w_addr = i_unaligned ? {i_addr[31:2], 2'b00} : i_addr;

    assign w_reserved = (i_mode > DM_WORD);
    assign w_misalign = !i_unaligned &&
                        (((i_mode == DM_HALF) && i_addr[0]) ||
                         ((i_mode == DM_WORD) && (i_addr[1:0] != 2'b00)));

    assign w_in_dm    = (w_addr <= DM_TOP);
    assign w_in_t0    = (w_addr >= T0_BASE) && (w_addr <= T0_BASE + T_BLOCK_LAST);
    assign w_in_t1    = (w_addr >= T1_BASE) && (w_addr <= T1_BASE + T_BLOCK_LAST);
    assign w_in_timer = w_in_t0 || w_in_t1;

    assign w_cnt_hit  = (w_addr == T0_BASE + T_CNT_OFS) ||
                        (w_addr == T1_BASE + T_CNT_OFS);

    // Timer registers are word-only and COUNT is read-only.
    assign w_timer_fault = w_in_timer &&
                           ((i_mode != DM_WORD) || i_unaligned ||
                            (i_is_store && w_cnt_hit));

    assign o_fault = w_reserved || w_misalign || w_timer_fault ||
                     !(w_in_dm || w_in_timer);

endmodule

// File: rtl/exc_checker.sv
// Memory-stage exception checker: merges the upstream exception code with
// data-memory access faults and registers the result for the next stage.
module exc_checker
    import exc_pkg::*;
#(
    parameter logic [31:0] DM_TOP    = DEF_DM_TOP,
    parameter logic [31:0] T0_BASE   = DEF_T0_BASE,
    parameter logic [31:0] T1_BASE   = DEF_T1_BASE,
    parameter logic [31:0] T_CNT_OFS = DEF_T_CNT_OFS
) (
    input  logic        EC_i_clk,
    input  logic        EC_i_reset,
    input  logic [4:0]  EC_i_E_ExcCode,
    input  logic        EC_i_DM_WEnable,
    input  logic        EC_i_DM_REnable,
    input  logic [31:0] EC_i_Addr,
    input  logic [3:0]  EC_i_DM_Mode,
    input  logic        EC_i_Unaligned,
    output logic [4:0]  EC_o_ExcCode
);

    logic       w_mem;
    logic       w_fault;
    logic [4:0] w_mem_code;
    logic [4:0] w_next;
    logic [4:0] r_exc;

    assign w_mem      = EC_i_DM_WEnable || EC_i_DM_REnable;
    assign w_mem_code = EC_i_DM_WEnable ? EXC_ADES : EXC_ADEL;

    exc_addr_fault #(
        .DM_TOP    (DM_TOP),
        .T0_BASE   (T0_BASE),
        .T1_BASE   (T1_BASE),
        .T_CNT_OFS (T_CNT_OFS)
    ) u_addr_fault (
        .i_addr      (EC_i_Addr),
        .i_mode      (EC_i_DM_Mode),
        .i_unaligned (EC_i_Unaligned),
        .i_is_store  (EC_i_DM_WEnable),
        .o_fault     (w_fault)
    );

    // An overflowed load/store address becomes an address error, not Ov.
    always_comb begin
        w_next = EXC_NONE;
        if ((EC_i_E_ExcCode != EXC_NONE) && (EC_i_E_ExcCode != EXC_OV)) begin
            w_next = EC_i_E_ExcCode;
        end else if (EC_i_E_ExcCode == EXC_OV) begin
            w_next = w_mem ? w_mem_code : EXC_OV;
        end else if (w_mem && w_fault) begin
            w_next = w_mem_code;
        end
    end

    always_ff @(posedge EC_i_clk or posedge EC_i_reset) begin
        if (EC_i_reset) begin
            r_exc <= EXC_NONE;
        end else begin
            r_exc <= w_next;
        end
    end

    assign EC_o_ExcCode = r_exc;

endmodule

// File: tb/tb_exc_checker.sv
// Bench for exc_checker: directed cases plus randomized accesses checked
// against a rule-level reference model through an expected-value queue.
module tb_exc_checker;

    logic        clk;
    logic        rst;
    logic [4:0]  e_code;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [3:0]  mode;
    logic        unal;
    logic [4:0]  exc_out;

    logic [4:0]  exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    exc_checker dut (
        .EC_i_clk        (clk),
        .EC_i_reset      (rst),
        .EC_i_E_ExcCode  (e_code),
        .EC_i_DM_WEnable (we),
        .EC_i_DM_REnable (re),
        .EC_i_Addr       (addr),
        .EC_i_DM_Mode    (mode),
        .EC_i_Unaligned  (unal),
        .EC_o_ExcCode    (exc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference written from the access rules: size = 2**mode, alignment by modulo,
    // and the address map as a list of byte ranges.
    function automatic logic [4:0] ref_exc(input logic [4:0] e, input logic w, input logic r,
                                           input logic [31:0] a, input logic [3:0] m,
                                           input logic u);
        logic [4:0]      ac;
        longint unsigned eff;
        longint unsigned size;
        longint unsigned bases[2];
        ac = w ? 5'd5 : 5'd4;
        bases[0] = 64'h7F00;
        bases[1] = 64'h7F10;
        if (e != 0 && e != 12) return e;
        if (e == 12) return (w || r) ? ac : 5'd12;
        if (!(w || r)) return 5'd0;
        if (m > 2) return ac;
        size = 64'd1 << m;
        if (!u && (longint'(a) % size) != 0) return ac;
        eff = u ? (longint'(a) / 4) * 4 : longint'(a);
        if (eff <= 64'h2FFF) return 5'd0;
        for (int i = 0; i < 2; i++) begin
            if (eff >= bases[i] && eff < bases[i] + 12) begin
                if (m != 2 || u) return ac;
                if (w && (eff - bases[i]) == 8) return ac;
                return 5'd0;
            end
        end
        return ac;
    endfunction

    task automatic drive(input logic [4:0] e, input logic w, input logic r,
                         input logic [31:0] a, input logic [3:0] m, input logic u);
        @(negedge clk);
        e_code = e; we = w; re = r; addr = a; mode = m; unal = u;
        exp_q.push_back(ref_exc(e, w, r, a, m, u));
    endtask

    task automatic apply(input string tag, input logic [4:0] e, input logic w, input logic r,
                         input logic [31:0] a, input logic [3:0] m, input logic u);
        logic [4:0] exp;
        drive(e, w, r, a, m, u);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check_val(tag, exc_out, exp);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 32'h3010));
            1: return 32'($urandom_range(32'h2FF0, 32'h3008));
            2: return 32'($urandom_range(32'h7EF8, 32'h7F20));
            3: return {$urandom_range(0, 1) ? 28'hFFFF_FFF : 28'h0000_7F0, 4'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] rand_e();
        case ($urandom_range(0, 5))
            0, 1, 2: return 5'd0;
            3: return 5'd12;
            4: return 5'd10;
            default: return 5'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        e_code = '0; we = 0; re = 0; addr = '0; mode = '0; unal = 0;
        #2;
        check_val("reset_initial", exc_out, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_held", exc_out, 5'd0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset from a nonzero output.
        apply("store_half_mis_pre_rst", 5'd0, 1, 0, 32'h5FD, 4'd1, 0);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_reset", exc_out, 5'd0);
        @(posedge clk);
        #1;
        check_val("reset_held_edge", exc_out, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        apply("idle_after_reset", 5'd0, 0, 0, 32'h0, 4'd0, 0);

        apply("store_byte_5fd",     5'd0,  1, 0, 32'h5FD,   4'd0, 0);
        apply("store_half_5fd",     5'd0,  1, 0, 32'h5FD,   4'd1, 0);
        apply("load_word_t0_04",    5'd0,  0, 1, 32'h7F04,  4'd2, 0);
        apply("store_t0_count",     5'd0,  1, 0, 32'h7F08,  4'd2, 0);
        apply("store_t1_count",     5'd0,  1, 0, 32'h7F18,  4'd2, 0);
        apply("store_t0_04",        5'd0,  1, 0, 32'h7F04,  4'd2, 0);
        apply("ov_load",            5'd12, 0, 1, 32'h3204,  4'd2, 0);
        apply("ov_no_mem",          5'd12, 0, 0, 32'h3204,  4'd2, 0);
        apply("pass_through_10",    5'd10, 0, 1, 32'h15152, 4'd2, 0);
        apply("timer_byte_unal",    5'd0,  0, 1, 32'h7F03,  4'd0, 1);
        apply("unal_word_2ffe",     5'd0,  0, 1, 32'h2FFE,  4'd2, 1);
        apply("load_word_15152",    5'd0,  0, 1, 32'h15152, 4'd2, 0);
        apply("load_word_3000",     5'd0,  0, 1, 32'h3000,  4'd2, 0);
        apply("load_word_2ffc",     5'd0,  0, 1, 32'h2FFC,  4'd2, 0);
        apply("reserved_mode_7",    5'd0,  0, 1, 32'h0,     4'd7, 0);
        apply("we_re_3000",         5'd0,  1, 1, 32'h3000,  4'd2, 0);
        apply("top_wrap_fffffffc",  5'd0,  0, 1, 32'hFFFF_FFFC, 4'd2, 0);
        apply("t1_last_word",       5'd0,  0, 1, 32'h7F18,  4'd2, 0);
        apply("t1_past_end",        5'd0,  0, 1, 32'h7F1C,  4'd2, 0);
        apply("no_mem_bad_addr",    5'd0,  0, 0, 32'hDEAD_BEEF, 4'd9, 0);

        for (int i = 0; i < 600; i++) begin
            logic [3:0] m;
            logic [1:0] acc;
            m = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            acc = 2'($urandom);
            apply("random", rand_e(), acc[1], acc[0], rand_addr(), m, 1'($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_tests);
        $fatal(1);
    end

endmodule
